// File: rtl/os_dram_bridge_pkg.sv
// os_dram_bridge_pkg: shared types, DRAM base address and Info_64 byte-order helper.
package os_dram_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } bridge_state_e;

    localparam logic [16:0] DRAM_BASE = 17'h10000;

    // DRAM words are little-endian relative to Info_64, so byte 0 lands in bits [63:56]
    function automatic logic [63:0] byte_swap(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = d[56-8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/os_dram_bridge.sv
// os_dram_bridge: turns single-cycle core record requests into sequential AXI4-Lite
// transactions with exactly one request in flight and a one-cycle completion pulse.
module os_dram_bridge
    import os_dram_bridge_pkg::*;
#(
    parameter int                ADDR_W    = 17,
    parameter int                DATA_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DRAM_BASE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              C_in_valid,
    input  logic              C_r_wb,
    input  logic [7:0]        C_addr,
    input  logic [DATA_W-1:0] C_data_w,
    output logic              C_out_valid,
    output logic [DATA_W-1:0] C_data_r,
    output logic              C_resp_err,
    output logic              AR_VALID,
    output logic [ADDR_W-1:0] AR_ADDR,
    input  logic              AR_READY,
    input  logic              R_VALID,
    input  logic [DATA_W-1:0] R_DATA,
    input  logic [1:0]        R_RESP,
    output logic              R_READY,
    output logic              AW_VALID,
    output logic [ADDR_W-1:0] AW_ADDR,
    input  logic              AW_READY,
    output logic              W_VALID,
    output logic [DATA_W-1:0] W_DATA,
    input  logic              W_READY,
    input  logic              B_VALID,
    input  logic [1:0]        B_RESP,
    output logic              B_READY
);

    bridge_state_e     state_q, state_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d, aw_addr_q, aw_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d, data_r_q, data_r_d;
    logic              err_q, err_d;
    logic              ar_valid_q, r_ready_q, aw_valid_q, w_valid_q, b_ready_q, out_valid_q;
    logic [ADDR_W-1:0] rec_addr;

    assign rec_addr = BASE_ADDR + ADDR_W'({C_addr, 3'b000});

    always_comb begin
        state_d   = state_q;
        ar_addr_d = ar_addr_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        data_r_d  = data_r_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: if (C_in_valid) begin
                state_d = C_r_wb ? S_AR : S_AW;
                if (C_r_wb) ar_addr_d = rec_addr;
                else begin
                    aw_addr_d = rec_addr;
                    w_data_d  = byte_swap(C_data_w);
                end
            end
            S_AR:   if (ar_valid_q && AR_READY) state_d = S_R;
            S_R:    if (r_ready_q && R_VALID) begin
                data_r_d = byte_swap(R_DATA);
                err_d    = R_RESP != 2'b00;
                state_d  = S_DONE;
            end
            S_AW:   if (aw_valid_q && AW_READY) state_d = S_W;
            S_W:    if (w_valid_q && W_READY) state_d = S_B;
            S_B:    if (b_ready_q && B_VALID) begin
                err_d   = B_RESP != 2'b00;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they rise on state entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ar_addr_q   <= '0;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            data_r_q    <= '0;
            err_q       <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ar_addr_q   <= ar_addr_d;
            aw_addr_q   <= aw_addr_d;
            w_data_q    <= w_data_d;
            data_r_q    <= data_r_d;
            err_q       <= err_d;
            ar_valid_q  <= state_d == S_AR;
            r_ready_q   <= state_d == S_R;
            aw_valid_q  <= state_d == S_AW;
            w_valid_q   <= state_d == S_W;
            b_ready_q   <= state_d == S_B;
            out_valid_q <= state_d == S_DONE;
        end
    end

    assign C_out_valid = out_valid_q;
    assign C_data_r    = data_r_q;
    assign C_resp_err  = err_q;
    assign AR_VALID    = ar_valid_q;
    assign AR_ADDR     = ar_addr_q;
    assign R_READY     = r_ready_q;
    assign AW_VALID    = aw_valid_q;
    assign AW_ADDR     = aw_addr_q;
    assign W_VALID     = w_valid_q;
    assign W_DATA      = w_data_q;
    assign B_READY     = b_ready_q;

endmodule

// File: tb/tb_os_dram_bridge.sv
// tb_os_dram_bridge: table-driven directed checks of os_dram_bridge plus hand-written
// backpressure, spurious-strobe and mid-transaction reset sequences.
module tb_os_dram_bridge;
    import os_dram_bridge_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        C_in_valid, C_r_wb, C_out_valid, C_resp_err;
    logic [7:0]  C_addr;
    logic [63:0] C_data_w, C_data_r, R_DATA, W_DATA;
    logic        AR_VALID, AR_READY, R_VALID, R_READY, AW_VALID, AW_READY;
    logic        W_VALID, W_READY, B_VALID, B_READY;
    logic [16:0] AR_ADDR, AW_ADDR;
    logic [1:0]  R_RESP, B_RESP;

    os_dram_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr), .C_data_w(C_data_w),
        .C_out_valid(C_out_valid), .C_data_r(C_data_r), .C_resp_err(C_resp_err),
        .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
        .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
        .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
        .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
        .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [7:0]  addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [1:0]  resp;
        logic [16:0] exp_addr;
        logic [63:0] exp_w;
        logic [63:0] exp_cdr;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t        tbl[6];
    int          checks = 0, errors = 0;
    int          ar_stall, r_at;
    logic [63:0] spur;
    logic [63:0] rdata;
    logic [1:0]  rresp, bresp;
    int          out_cnt, out_cyc, ar_hs, r_hs, aw_hs, w_hs, b_hs, unstable;
    logic [16:0] addr_seen;
    logic [63:0] w_seen, cdr_seen;
    logic        err_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one request at cycle 0 and acts as the AXI slave while monitoring all channels
    task automatic run_txn(input logic rd, input logic [7:0] addr, input logic [63:0] wdata);
        int          tail = -1;
        logic        pv_ar = 0, pv_aw = 0, pv_w = 0, pr_ar = 0, pr_aw = 0, pr_w = 0;
        logic [16:0] pa_ar = '0, pa_aw = '0;
        logic [63:0] pd_w = '0;
        out_cnt = 0; out_cyc = -1; ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        unstable = 0; addr_seen = '0; w_seen = '0; cdr_seen = '0; err_seen = 1'bx;
        for (int c = 0; c < 60 && tail != 0; c++) begin
            @(negedge clk);
            if (C_out_valid) begin
                out_cnt++; out_cyc = c; cdr_seen = C_data_r; err_seen = C_resp_err; tail = 3;
            end
            if (pv_ar && !pr_ar && (!AR_VALID || AR_ADDR !== pa_ar)) unstable++;
            if (pv_aw && !pr_aw && (!AW_VALID || AW_ADDR !== pa_aw)) unstable++;
            if (pv_w && !pr_w && (!W_VALID || W_DATA !== pd_w)) unstable++;
            if (AR_VALID) addr_seen = AR_ADDR;
            if (AW_VALID) addr_seen = AW_ADDR;
            C_in_valid = (c == 0) || spur[c];
            C_r_wb     = (c == 0) ? rd : 1'b1;
            C_addr     = addr;
            C_data_w   = wdata;
            AR_READY   = c >= ar_stall;
            R_VALID    = c >= r_at;
            R_DATA     = rdata;
            R_RESP     = rresp;
            AW_READY   = 1'b1;
            W_READY    = 1'b1;
            B_VALID    = 1'b1;
            B_RESP     = bresp;
            ar_hs += int'(AR_VALID && AR_READY);
            r_hs  += int'(R_VALID && R_READY);
            aw_hs += int'(AW_VALID && AW_READY);
            b_hs  += int'(B_VALID && B_READY);
            if (W_VALID && W_READY) begin
                w_hs++; w_seen = W_DATA;
            end
            pv_ar = AR_VALID; pr_ar = AR_READY; pa_ar = AR_ADDR;
            pv_aw = AW_VALID; pr_aw = AW_READY; pa_aw = AW_ADDR;
            pv_w  = W_VALID;  pr_w  = W_READY;  pd_w  = W_DATA;
            if (tail > 0) tail--;
        end
        C_in_valid = 1'b0;
    endtask

    initial begin
        int rst_out;
        tbl[0] = '{1'b1, 8'h03, 64'h0, 64'h0123456789ABCDEF, 2'b00, 17'h10018, 64'h0, 64'hEFCDAB8967452301, 1'b0, 3};
        tbl[1] = '{1'b0, 8'hFF, 64'h1122334455667788, 64'h0, 2'b00, 17'h107F8, 64'h8877665544332211, 64'hEFCDAB8967452301, 1'b0, 4};
        tbl[2] = '{1'b0, 8'h00, 64'h0001020304050607, 64'h0, 2'b10, 17'h10000, 64'h0706050403020100, 64'hEFCDAB8967452301, 1'b1, 4};
        tbl[3] = '{1'b1, 8'h80, 64'h0, 64'hA5A50000FFFF1234, 2'b00, 17'h10400, 64'h0, 64'h3412FFFF0000A5A5, 1'b0, 3};
        tbl[4] = '{1'b1, 8'h10, 64'h0, 64'hDEADBEEFCAFEF00D, 2'b11, 17'h10080, 64'h0, 64'h0DF0FECAEFBEADDE, 1'b1, 3};
        tbl[5] = '{1'b0, 8'h01, 64'hFFEEDDCCBBAA9988, 64'h0, 2'b00, 17'h10008, 64'h8899AABBCCDDEEFF, 64'h0DF0FECAEFBEADDE, 1'b0, 4};
        C_in_valid = 0; C_r_wb = 0; C_addr = 0; C_data_w = 0;
        AR_READY = 0; R_VALID = 0; R_DATA = 0; R_RESP = 0;
        AW_READY = 0; W_READY = 0; B_VALID = 0; B_RESP = 0;
        ar_stall = 0; r_at = 0; spur = '0; rdata = '0; rresp = 0; bresp = 0;

        repeat (2) @(negedge clk);
        chk("reset_ctrl", 64'({C_out_valid, C_resp_err, AR_VALID, R_READY, AW_VALID, W_VALID, B_READY}), 64'h0);
        chk("reset_addr", 64'({AR_ADDR, AW_ADDR}), 64'h0);
        chk("reset_wdata", W_DATA, 64'h0);
        chk("reset_cdr", C_data_r, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            rdata = tbl[i].rdata; rresp = tbl[i].resp; bresp = tbl[i].resp;
            run_txn(tbl[i].rd, tbl[i].addr, tbl[i].wdata);
            chk($sformatf("v%0d_out_cnt", i), 64'(out_cnt), 64'd1);
            chk($sformatf("v%0d_latency", i), 64'(out_cyc), 64'(tbl[i].exp_lat));
            chk($sformatf("v%0d_addr", i), 64'(addr_seen), 64'(tbl[i].exp_addr));
            chk($sformatf("v%0d_cdr", i), cdr_seen, tbl[i].exp_cdr);
            chk($sformatf("v%0d_err", i), 64'(err_seen), 64'(tbl[i].exp_err));
            chk($sformatf("v%0d_stable", i), 64'(unstable), 64'd0);
            if (tbl[i].rd) begin
                chk($sformatf("v%0d_rd_hs", i), 64'({ar_hs[3:0], r_hs[3:0], aw_hs[3:0], w_hs[3:0], b_hs[3:0]}), 64'h11000);
            end else begin
                chk($sformatf("v%0d_wdata", i), w_seen, tbl[i].exp_w);
                chk($sformatf("v%0d_wr_hs", i), 64'({ar_hs[3:0], r_hs[3:0], aw_hs[3:0], w_hs[3:0], b_hs[3:0]}), 64'h00111);
            end
        end

        ar_stall = 5; r_at = 13; rdata = 64'h8899AABBCCDDEEFF; rresp = 2'b00;
        run_txn(1'b1, 8'h42, 64'h0);
        chk("bp_out_cnt", 64'(out_cnt), 64'd1);
        chk("bp_latency", 64'(out_cyc), 64'd14);
        chk("bp_stable", 64'(unstable), 64'd0);
        chk("bp_addr", 64'(addr_seen), 64'h10210);
        chk("bp_cdr", cdr_seen, 64'hFFEEDDCCBBAA9988);
        chk("bp_ar_hs", 64'(ar_hs), 64'd1);

        ar_stall = 0; r_at = 0; bresp = 2'b00; spur = 64'h14;
        run_txn(1'b0, 8'h20, 64'h0102030405060708);
        spur = '0;
        chk("spur_out_cnt", 64'(out_cnt), 64'd1);
        chk("spur_latency", 64'(out_cyc), 64'd4);
        chk("spur_hs", 64'({ar_hs[3:0], r_hs[3:0], aw_hs[3:0], w_hs[3:0], b_hs[3:0]}), 64'h00111);
        chk("spur_addr", 64'(addr_seen), 64'h10100);
        chk("spur_wdata", w_seen, 64'h0807060504030201);

        @(negedge clk);
        C_in_valid = 1'b1; C_r_wb = 1'b1; C_addr = 8'h05; AR_READY = 1'b1; R_VALID = 1'b0;
        @(negedge clk);
        C_in_valid = 1'b0;
        @(negedge clk);
        chk("mr_in_r_state", 64'(R_READY), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_ctrl_zero", 64'({C_out_valid, C_resp_err, AR_VALID, R_READY, AW_VALID, W_VALID, B_READY}), 64'h0);
        chk("mr_addr_zero", 64'({AR_ADDR, AW_ADDR}), 64'h0);
        chk("mr_wdata_zero", W_DATA, 64'h0);
        chk("mr_cdr_zero", C_data_r, 64'h0);
        R_VALID = 1'b1; rst_out = 0;
        repeat (3) begin
            @(negedge clk);
            rst_out += int'(C_out_valid);
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            rst_out += int'(C_out_valid);
        end
        chk("mr_no_out", 64'(rst_out), 64'd0);
        rdata = 64'h0F1E2D3C4B5A6978; rresp = 2'b00;
        run_txn(1'b1, 8'h05, 64'h0);
        chk("mr_after_cnt", 64'(out_cnt), 64'd1);
        chk("mr_after_lat", 64'(out_cyc), 64'd3);
        chk("mr_after_addr", 64'(addr_seen), 64'h10028);
        chk("mr_after_cdr", cdr_seen, 64'h78695A4B3C2D1E0F);
        chk("mr_after_err", 64'(err_seen), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/os_dram_bridge.md
Name: os_dram_bridge

Overview:
- Sits between the online-shopping core and the pseudo-DRAM.
- Turns one-cycle core requests (read or write of one 64-bit Info_64 record, indexed by 8-bit user/shop ID) into AXI4-Lite transactions.
- Returns read data or write completion to the core with a single-cycle C_out_valid pulse.
- Handles exactly one outstanding request; AXI read and write channels are used in strict sequence.

Parameters:
- BASE_ADDR, 17'h10000, DRAM byte address of record 0.
- ADDR_W, 17, AXI address width.
- DATA_W, 64, record / AXI data width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- C_in_valid  in  1  request strobe, one cycle
- C_r_wb  in  1  1 = read, 0 = write; sampled with C_in_valid
- C_addr  in  8  record index (user/shop ID)
- C_data_w  in  64  write record in Info_64 layout
- C_out_valid  out  1  one-cycle completion pulse
- C_data_r  out  64  read record in Info_64 layout
- C_resp_err  out  1  last AXI response was not OKAY
- AR_VALID  out  1  read-address valid
- AR_ADDR  out  17  read address
- AR_READY  in  1  read-address ready
- R_VALID  in  1  read-data valid
- R_DATA  in  64  read data
- R_RESP  in  2  read response
- R_READY  out  1  read-data ready
- AW_VALID  out  1  write-address valid
- AW_ADDR  out  17  write address
- AW_READY  in  1  write-address ready
- W_VALID  out  1  write-data valid
- W_DATA  out  64  write data
- W_READY  in  1  write-data ready
- B_VALID  in  1  write-response valid
- B_RESP  in  2  write response
- B_READY  out  1  write-response ready

Behaviour:
- Reset values: all outputs 0, including valids, readies, addresses, data, C_data_r and C_resp_err. FSM state is IDLE.
- Reset is asynchronous and may assert mid-transaction. It aborts the transaction with no completion pulse and returns to IDLE.
- On acceptance in IDLE, C_r_wb, C_addr and C_data_w are registered.
- Address: BASE_ADDR + {C_addr, 3'b000}, 17 bits, no overflow possible. Examples: C_addr 8'hFF gives 17'h107F8; C_addr 8'h00 gives 17'h10000.
- Byte order: the DRAM word is little-endian relative to Info_64.
  - W_DATA is the byte-reversal of C_data_w: byte0 to bits[63:56] and so on.
  - C_data_r is the byte-reversal of R_DATA.
- FSM states: IDLE, AR, R, AW, W, B, DONE.
  - IDLE: C_in_valid with C_r_wb=1 goes to AR. C_in_valid with C_r_wb=0 goes to AW.
  - AR: AR_VALID=1 with AR_ADDR stable. Go to R on AR_VALID&AR_READY.
  - R: R_READY=1. On R_VALID, capture data into C_data_r, set C_resp_err=(R_RESP!=2'b00), go to DONE.
  - AW: AW_VALID=1 with AW_ADDR stable. Go to W on AW_READY.
  - W: W_VALID=1 with W_DATA stable. Go to B on W_READY.
  - B: B_READY=1. On B_VALID, set C_resp_err=(B_RESP!=2'b00), go to DONE. C_data_r is unchanged.
  - DONE: C_out_valid=1 for exactly one cycle, then IDLE.
- AXI outputs are registered. Each VALID rises the cycle after state entry and drops the cycle after the handshake.
- VALID never drops before READY. Address and data are held constant while VALID is high.
- Minimum latency, with ready and valid inputs already high:
  - Read: C_in_valid at cycle 0; AR at 1; R at 2; C_out_valid at 3.
  - Write: C_out_valid at cycle 4.
- No timeout: a stalled slave stalls the bridge indefinitely.
- C_in_valid outside IDLE is ignored, with no queueing. The core must not issue it before C_out_valid.
- C_in_valid in the same cycle as C_out_valid is also ignored.
- READY inputs asserted before VALID are allowed. A handshake is counted only when both are high in the same cycle.
- R_VALID or B_VALID arriving in an unexpected state is ignored.
- C_resp_err holds until the next completion.

Decomposition:
- Shared usertype package additions:
  - Bridge state enum.
  - DRAM_BASE constant 17'h10000.
  - A byte-swap function, reused by the core's checker model.
- The bridge is flat with no sub-modules. The one FSM fits in roughly 200 lines.

Test Plan:
- Read, zero wait. Stimulus: C_addr=8'h03, R_DATA=64'h0123456789ABCDEF, R_RESP=0.
  - Required: AR_ADDR=17'h10018.
  - Required: C_data_r=64'hEFCDAB8967452301 with C_out_valid at cycle 3.
  - Required: C_resp_err=0.
- Write, zero wait. Stimulus: C_addr=8'hFF, C_data_w=64'h1122334455667788.
  - Required: AW_ADDR=17'h107F8.
  - Required: W_DATA=64'h8877665544332211.
  - Required: C_out_valid at cycle 4.
- Backpressure. Hold AR_READY low 5 cycles, then R_VALID low 7 cycles.
  - Required: AR_VALID and AR_ADDR stable throughout.
  - Required: exactly one C_out_valid, 14 cycles after the request.
- Error response. Stimulus: B_RESP=2'b10 on a write.
  - Required: C_resp_err=1.
  - Required: a following OKAY read clears it to 0.
- Mid-read reset. Assert rst_n=0 while in R state.
  - Required: all outputs 0 immediately, with no C_out_valid.
  - Required: a new read after release completes normally.
- Spurious strobe. Issue C_in_valid again during a pending write.
  - Required: ignored, with exactly one AW/W/B sequence and one C_out_valid.
